xip_flash_ctrl: RTL and testbench
=================================

# xip_flash_ctrl

Execute-in-place flash read initiator: accepts single-word read requests from the on-chip bus side and performs an SPI read transaction against the external flash over `xip_cs_n`/`xip_sck`/`xip_dout`/`xip_douten`/`xip_din`. It is the initiator that drives the flash model in the simulation top and the real flash on the FPGA, and returns one little-endian 32-bit word per request.

## Interface
Parameters:
- `CLK_DIV`, 1: SCK half-period in `clk` cycles; legal range 1..255.
- `CS_HIGH_CYCLES`, 2: minimum `clk` cycles `xip_cs_n` stays high between transactions; legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic in this domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: read request valid.
- `req_ready` output 1: controller idle; request accepted when `req_valid && req_ready`.
- `req_addr` input 24: flash byte address; any alignment allowed.
- `rsp_valid` output 1: one-cycle pulse; `rsp_data` is valid.
- `rsp_data` output 32: read word; held until the next `rsp_valid`.
- `xip_cs_n` output 1: flash chip select, active-low.
- `xip_sck` output 1: SPI clock, mode 0.
- `xip_dout` output 4: IO[3:0] output values.
- `xip_douten` output 4: per-line output enable, 1 = driven.
- `xip_din` input 4: IO[3:0] input values.

## Operation
- States: IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (quad build only, 8 SCK), DATA (32 bits serial / 8 nibbles quad), GAP (CS high).
- IDLE: `req_ready`=1; on accept, latch `req_addr` and go to CMD; `req_ready` drops on the next edge.
- CMD/ADDR: MSB first on `xip_dout[0]`, one bit per SCK. Command 0x03 (serial) or 0x6B (quad).
- Serial DATA: sample `xip_din[1]`. Quad DUMMY/DATA: `xip_douten`=4'b0000; sample `xip_din[3:0]`, high nibble first.
- Byte order: bits MSB first within a byte; first received byte goes to `rsp_data[7:0]`, fourth to `rsp_data[31:24]`.
- Line drive outside quad DUMMY/DATA: `xip_douten`=4'b1101, `xip_dout[3:2]`=2'b11 (WP#/HOLD# inactive), `xip_dout[1]`=0.
- After the last sample: `rsp_valid` pulses, `rsp_data` updates, `xip_cs_n` rises, and the controller enters GAP. After `CS_HIGH_CYCLES` cycles it returns to IDLE.
- `req_valid` while busy is ignored; there is no queueing.

## Timing
- Reset values: `xip_cs_n`=1, `xip_sck`=0, `xip_dout`=4'b1100, `xip_douten`=4'b1101, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- `req_ready` rises on the first `clk` edge after `rst_n` deasserts.
- All outputs are registered.
- Accept at edge T:
  - At T+1: `xip_cs_n`=0, `xip_sck`=0, and `xip_dout[0]` = command bit 7.
  - SCK toggles every `CLK_DIV` cycles.
  - On the edge that sets `xip_sck` 0->1, `xip_din` is captured using its value before that edge.
  - On the edge that sets `xip_sck` 1->0, the next output bit is driven.
- Serial transaction is 64 SCK periods; `rsp_valid` is high at T+1+128·`CLK_DIV` (T+129 for `CLK_DIV`=1).
- Quad transaction is 48 SCK periods; `rsp_valid` is high at T+1+96·`CLK_DIV`.
- `xip_cs_n` rises in the same cycle `rsp_valid` is high. `xip_sck` is 0 whenever `xip_cs_n`=1.
- `req_ready` returns `CS_HIGH_CYCLES` cycles after `rsp_valid`, so back-to-back requests cannot shorten the CS-high gap.
- `rst_n` asserted mid-transaction: all outputs take reset values immediately. No `rsp_valid` is produced, and the aborted transaction is never resumed.
- Address 0xFFFFFF read: the address is sent as-is. Flash-side wrap is not the controller's concern.

## Configuration
- `XIP_QUAD_EN` defined: command 0x6B, 8 dummy SCK, and quad data phase with `xip_douten`=0 during DUMMY/DATA.
- `XIP_QUAD_EN` undefined: command 0x03, no DUMMY state, and serial data on `xip_din[1]`. `xip_douten` stays 4'b1101 throughout.
- Request/response interface and byte order are identical in both builds.

## Test plan
- Reset release, then a serial read at addr 0x000000 with flash bytes 0x13,0x05,0x00,0x00 -> `rsp_data`=0x00000513 at T+129 (`CLK_DIV`=1). Bench checks that 0x03 then 0x000000 are shifted on IO0.
- `CLK_DIV`=3, read at addr 0x000104 -> `rsp_valid` at T+385. Bench checks that SCK high/low each last 3 cycles and that `xip_cs_n` is high for ≥2 cycles before `req_ready`.
- Two requests held back-to-back -> second accept occurs exactly 2 cycles after the first `rsp_valid`. Bench checks that `req_valid` asserted during a transaction is not accepted.
- `XIP_QUAD_EN`, addr 0x000010, bytes 0xAA,0xBB,0xCC,0xDD -> `rsp_data`=0xDDCCBBAA at T+97. Bench checks that `xip_douten` is 0 from the first dummy SCK through the last data nibble.
- `rst_n` pulsed low during the ADDR phase -> `xip_cs_n`=1 and `xip_sck`=0 immediately, no `rsp_valid`. The next request then completes normally with correct data.

Source files
------------

// File: rtl/xip_flash_ctrl.sv
// xip_flash_ctrl
//   Execute-in-place flash read initiator. Takes one single-word read request
//   at a time and runs a mode-0 SPI read against the external flash. The four
//   received bytes are returned as one little-endian word.
//
//   Build option: define XIP_QUAD_EN for a quad-output fast read (0x6B, 8 dummy
//   clocks, nibble-wide data on IO[3:0]). Left undefined, the block issues a
//   plain serial read (0x03) and samples data on IO1.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     req_valid/req_ready  request handshake, accepted when both are high
//     req_addr[23:0]       flash byte address, latched on accept
//     rsp_valid            one-cycle pulse when rsp_data is updated
//     rsp_data[31:0]       read word, held until the next response
//     xip_cs_n, xip_sck    flash chip select and SPI clock
//     xip_dout/xip_douten  IO[3:0] output values and per-line output enables
//     xip_din              IO[3:0] input values
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | req_ready high, waiting for a request
//   ST_CMD   | shifting the 8-bit read command out on IO0
//   ST_ADDR  | shifting the 24-bit address out on IO0
//   ST_DUMMY | quad build only: 8 dummy clocks, all IO lines released
//   ST_DATA  | sampling 32 data bits (serial) or 8 nibbles (quad)
//   ST_GAP   | chip select high for CS_HIGH_CYCLES before the next request
module xip_flash_ctrl #(
    parameter int CLK_DIV        = 1,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        xip_cs_n,
    output logic        xip_sck,
    output logic [3:0]  xip_dout,
    output logic [3:0]  xip_douten,
    input  logic [3:0]  xip_din
);

`ifdef XIP_QUAD_EN
    localparam logic [7:0] READ_CMD  = 8'h6B;
    localparam logic [4:0] DATA_LAST = 5'd7;
`else
    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam logic [4:0] DATA_LAST = 5'd31;
`endif
    localparam logic [7:0] DIV_LOAD  = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(CS_HIGH_CYCLES - 1);
    localparam logic [3:0] OE_IDLE   = 4'b1101;
    localparam logic [3:0] DOUT_IDLE = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic [31:0] rx_next;
    logic [31:0] rsp_word;

`ifdef XIP_QUAD_EN
    assign rx_next = {rx_shift[27:0], xip_din};
`else
    // Serial reads only listen on IO1.
    logic unused_din;
    assign unused_din = ^{xip_din[3:2], xip_din[0]};
    assign rx_next    = {rx_shift[30:0], xip_din[1]};
`endif

    // The first byte received ends up in rx_shift[31:24]; it belongs in the
    // least significant byte of the response.
    assign rsp_word = {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            xip_cs_n   <= 1'b1;
            xip_sck    <= 1'b0;
            xip_dout   <= DOUT_IDLE;
            xip_douten <= OE_IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            gap_cnt    <= 4'd0;
            tx_shift   <= 32'd0;
            rx_shift   <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        state       <= ST_CMD;
                        xip_cs_n    <= 1'b0;
                        xip_sck     <= 1'b0;
                        tx_shift    <= {READ_CMD, req_addr};
                        xip_dout[0] <= READ_CMD[7];
                        div_cnt     <= DIV_LOAD;
                        bit_cnt     <= 5'd7;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!xip_sck) begin
                            // Rising SCK edge: capture the value the flash drove
                            // during the low half.
                            xip_sck <= 1'b1;
                            if (state == ST_DATA) begin
                                rx_shift <= rx_next;
                            end
                        end else begin
                            // Falling SCK edge: present the next output bit.
                            xip_sck     <= 1'b0;
                            tx_shift    <= {tx_shift[30:0], 1'b0};
                            xip_dout[0] <= (state == ST_CMD ||
                                            (state == ST_ADDR && bit_cnt != 5'd0))
                                           ? tx_shift[30] : 1'b0;
                            if (bit_cnt != 5'd0) begin
                                bit_cnt <= bit_cnt - 5'd1;
                            end else begin
                                case (state)
                                    ST_CMD: begin
                                        state   <= ST_ADDR;
                                        bit_cnt <= 5'd23;
                                    end
                                    ST_ADDR: begin
`ifdef XIP_QUAD_EN
                                        state      <= ST_DUMMY;
                                        bit_cnt    <= 5'd7;
                                        xip_douten <= 4'b0000;
`else
                                        state   <= ST_DATA;
                                        bit_cnt <= DATA_LAST;
`endif
                                    end
                                    ST_DUMMY: begin
                                        state   <= ST_DATA;
                                        bit_cnt <= DATA_LAST;
                                    end
                                    default: begin
                                        state      <= ST_GAP;
                                        gap_cnt    <= GAP_LOAD;
                                        xip_cs_n   <= 1'b1;
                                        xip_douten <= OE_IDLE;
                                        rsp_valid  <= 1'b1;
                                        rsp_data   <= rsp_word;
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xip_flash_ctrl.sv
`timescale 1ns/1ps
module tb_xip_flash_ctrl;
    localparam int N = 2;
`ifdef XIP_QUAD_EN
    localparam bit QUAD = 1'b1;
`else
    localparam bit QUAD = 1'b0;
`endif
    localparam logic [7:0] EXP_CMD = QUAD ? 8'h6B : 8'h03;
    localparam int PERIODS = QUAD ? 48 : 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, rsp_valid, cs_n, sck;
    logic [23:0] req_addr [N];
    logic [31:0] rsp_data [N];
    logic [3:0]  dout [N];
    logic [3:0]  douten [N];
    logic [3:0]  din [N] = '{default: 4'h0};

    logic [7:0] mem [256];
    int vec_cnt = 0;
    int err_cnt = 0;

    // flash model / protocol monitor state, owned by the monitor block
    logic [N-1:0] sck_q = '0;
    int          per [N]      = '{default: 0};
    int          run [N]      = '{default: 0};
    logic [31:0] fsh [N]      = '{default: 32'd0};
    int          half_err [N] = '{default: 0};
    int          mode_err [N] = '{default: 0};
    int          idle_err [N] = '{default: 0};
    int          rsp_cnt [N]  = '{default: 0};
    int          oe_off [N]   = '{default: 0};

    always #5 clk = ~clk;

    xip_flash_ctrl #(.CLK_DIV(1), .CS_HIGH_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .xip_cs_n(cs_n[0]), .xip_sck(sck[0]), .xip_dout(dout[0]),
        .xip_douten(douten[0]), .xip_din(din[0])
    );

    xip_flash_ctrl #(.CLK_DIV(3), .CS_HIGH_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .xip_cs_n(cs_n[1]), .xip_sck(sck[1]), .xip_dout(dout[1]),
        .xip_douten(douten[1]), .xip_din(din[1])
    );

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Expected word: four consecutive flash bytes, first byte least significant.
    function automatic logic [31:0] ref_word(input logic [23:0] a);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = mem[8'(a + 24'(i))];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Value the flash puts on IO[3:0] for SCK period p+1, given p periods done.
    function automatic logic [3:0] flash_drive(input logic [23:0] a, input int p,
                                               input logic [3:0] noise);
        logic [7:0] byt;
        int k;
        if (QUAD) begin
            if (p < 40 || p >= 48) return noise;
            k = p - 40;
            byt = mem[8'(a + 24'(k / 2))];
            return (k % 2 == 0) ? byt[7:4] : byt[3:0];
        end else begin
            if (p < 32 || p >= 64) return noise;
            k = p - 32;
            byt = mem[8'(a + 24'(k / 8))];
            return {noise[3:2], byt[7 - (k % 8)], noise[0]};
        end
    endfunction

    always @(posedge clk) begin
        #2;
        for (int g = 0; g < N; g++) begin
            sck_q[g] <= sck[g];
            if (rsp_valid[g]) rsp_cnt[g] <= rsp_cnt[g] + 1;
            if (cs_n[g]) begin
                per[g] <= 0;
                run[g] <= 0;
                if (sck[g] !== 1'b0 || douten[g] !== 4'b1101 || dout[g] !== 4'b1100)
                    idle_err[g] <= idle_err[g] + 1;
            end else begin
                if (douten[g] == 4'b0000) oe_off[g] <= oe_off[g] + 1;
                else if (douten[g] !== 4'b1101 || dout[g][3:1] !== 3'b110 || req_ready[g])
                    mode_err[g] <= mode_err[g] + 1;
                if (sck[g] != sck_q[g]) begin
                    if (run[g] != div_of(g)) half_err[g] <= half_err[g] + 1;
                    run[g] <= 1;
                end else begin
                    run[g] <= run[g] + 1;
                end
                if (sck[g] && !sck_q[g]) begin
                    per[g] <= per[g] + 1;
                    if (per[g] < 32) fsh[g] <= {fsh[g][30:0], dout[g][0]};
                    if (douten[g] !== ((QUAD && per[g] >= 32) ? 4'b0000 : 4'b1101))
                        mode_err[g] <= mode_err[g] + 1;
                end
                if (!sck[g] && sck_q[g])
                    din[g] <= flash_drive(fsh[g][23:0], per[g], 4'($urandom));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1. With hold set, req_valid stays high and
    // req_addr switches to a_next right after the accept.
    task automatic do_read(input int d, input logic [23:0] a, input bit hold,
                           input logic [23:0] a_next, output int waited);
        int n;
        int dv;
        int oe0;
        int rsp0;
        logic [31:0] exp;
        dv  = div_of(d);
        exp = ref_word(a);
        req_addr[d]  = a;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        waited = n;
        check("ready_wait", 32'(req_ready[d]), 32'd1);
        oe0  = oe_off[d];
        rsp0 = rsp_cnt[d];
        @(posedge clk); #1;
        if (hold) req_addr[d] = a_next;
        else req_valid[d] = 1'b0;
        check("cs_low_t1", 32'(cs_n[d]), 32'd0);
        check("sck_low_t1", 32'(sck[d]), 32'd0);
        check("ready_drop", 32'(req_ready[d]), 32'd0);
        check("cmd_bit7", 32'(dout[d][0]), 32'(EXP_CMD[7]));
        n = 1;
        while (!rsp_valid[d] && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_latency", 32'(n), 32'(1 + 2 * PERIODS * dv));
        check("rsp_data", rsp_data[d], exp);
        check("cs_high_at_rsp", 32'(cs_n[d]), 32'd1);
        check("cmd_sent", 32'(fsh[d][31:24]), 32'(EXP_CMD));
        check("addr_sent", 32'(fsh[d][23:0]), 32'(a));
        @(posedge clk); #1;
        check("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
        n = 1;
        while (!req_ready[d] && n < 50) begin
            check("cs_high_gap", 32'(cs_n[d]), 32'd1);
            @(posedge clk); #1; n++;
        end
        check("gap_len", 32'(n), 32'd2);
        check("rsp_count", 32'(rsp_cnt[d] - rsp0), 32'd1);
        check("oe_off_cycles", 32'(oe_off[d] - oe0), QUAD ? 32'(32 * dv) : 32'd0);
        check("sck_half_err", 32'(half_err[d]), 32'd0);
        check("line_mode_err", 32'(mode_err[d]), 32'd0);
        check("idle_lines_err", 32'(idle_err[d]), 32'd0);
    endtask

    initial begin
        int w;
        int r0;
        logic [23:0] a1;
        logic [23:0] a2;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[16] = 8'hAA; mem[17] = 8'hBB; mem[18] = 8'hCC; mem[19] = 8'hDD;
        req_addr[0] = 24'd0;
        req_addr[1] = 24'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check("rst_cs_n", 32'(cs_n[d]), 32'd1);
            check("rst_sck", 32'(sck[d]), 32'd0);
            check("rst_dout", 32'(dout[d]), 32'hC);
            check("rst_douten", 32'(douten[d]), 32'hD);
            check("rst_ready", 32'(req_ready[d]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rsp_data", rsp_data[d], 32'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst0", 32'(req_ready[0]), 32'd1);
        check("ready_after_rst1", 32'(req_ready[1]), 32'd1);

        do_read(0, 24'h000000, 1'b0, 24'h0, w);
        check("word_addr0", rsp_data[0], 32'h00000513);
        do_read(1, 24'h000104, 1'b0, 24'h0, w);
        do_read(0, 24'h000010, 1'b0, 24'h0, w);
        check("word_addr10", rsp_data[0], 32'hDDCCBBAA);

        // back-to-back: request held high through the first transaction
        a1 = 24'($urandom);
        a2 = 24'($urandom);
        do_read(0, a1, 1'b1, a2, w);
        do_read(0, a2, 1'b0, 24'h0, w);
        check("b2b_no_wait", 32'(w), 32'd0);

        // reset pulse during the address phase of the slow instance
        r0 = rsp_cnt[1];
        req_addr[1]  = 24'($urandom);
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("abort_busy", 32'(cs_n[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n[1]), 32'd1);
        check("abort_sck", 32'(sck[1]), 32'd0);
        check("abort_dout", 32'(dout[1]), 32'hC);
        check("abort_douten", 32'(douten[1]), 32'hD);
        check("abort_ready", 32'(req_ready[1]), 32'd0);
        check("abort_rsp_data", rsp_data[1], 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", 32'(req_ready[1]), 32'd1);
        repeat (400) @(posedge clk);
        #1;
        check("abort_no_rsp", 32'(rsp_cnt[1] - r0), 32'd0);
        check("abort_not_resumed", 32'(cs_n[1]), 32'd1);
        do_read(1, 24'h0000FE, 1'b0, 24'h0, w);

        do_read(0, 24'hFFFFFF, 1'b0, 24'h0, w);
        for (int i = 0; i < 6; i++) begin
            do_read(int'($urandom_range(0, 1)), 24'($urandom), 1'b0, 24'h0, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
